// File: rtl/nubus_oe_sequencer.sv
// rtl/nubus_oe_sequencer.sv - round-robin break-before-make sequencer for bus-switch oe_n pins
module nubus_oe_sequencer #(
  parameter int N_GRP       = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int MIN_ON      = 1
) (
  input  logic             nub_clkn,
  input  logic             nub_resetn,
  input  logic [N_GRP-1:0] req,
  input  logic             force_off,
  output logic [N_GRP-1:0] gnt,
  output logic [N_GRP-1:0] oe_n,
  output logic             busy
);

  localparam int IW = (N_GRP > 1) ? $clog2(N_GRP) : 1;
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int OW = (MIN_ON > 1) ? $clog2(MIN_ON + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_TURN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_GRP-1:0] oe_n_q, oe_n_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    w_q, w_d;
  logic [OW-1:0]    on_cnt_q, on_cnt_d;
  logic [DW-1:0]    dead_cnt_q, dead_cnt_d;
  // Low for the first edge after reset release so no switch closes on an edge
  // that may be too close to the asynchronous deassertion.
  logic             armed_q;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  int               scan_j;

  // Round-robin scan: first requesting bank at or above rr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_j    = 0;
    for (int k = 0; k < N_GRP; k++) begin
      scan_j = (int'(rr_q) + k) % N_GRP;
      if (!win_found && req[scan_j[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_j[IW-1:0];
      end
    end
  end

  // Next-state logic: grant from IDLE, hold for MIN_ON, then dead time in TURN.
  always_comb begin
    state_d    = state_q;
    oe_n_d     = oe_n_q;
    rr_d       = rr_q;
    w_d        = w_q;
    on_cnt_d   = on_cnt_q;
    dead_cnt_d = dead_cnt_q;
    if (force_off) begin
      // Kill wins over any grant or release in the same cycle; rr is left alone.
      state_d    = S_TURN;
      oe_n_d     = '1;
      dead_cnt_d = DW'(DEAD_CYCLES);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armed_q && win_found) begin
            state_d         = S_ON;
            w_d             = win_idx;
            oe_n_d          = '1;
            oe_n_d[win_idx] = 1'b0;
            on_cnt_d        = OW'(MIN_ON - 1);
          end
        end
        S_ON: begin
          if (!req[w_q] && (on_cnt_q == '0)) begin
            state_d    = S_TURN;
            oe_n_d     = '1;
            rr_d       = (w_q == IW'(N_GRP - 1)) ? '0 : w_q + IW'(1);
            dead_cnt_d = DW'(DEAD_CYCLES);
          end else if (on_cnt_q != '0) begin
            on_cnt_d = on_cnt_q - OW'(1);
          end
        end
        S_TURN: begin
          if (dead_cnt_q != '0) begin
            dead_cnt_d = dead_cnt_q - DW'(1);
          end
          if (dead_cnt_q <= DW'(1)) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          oe_n_d  = '1;
        end
      endcase
    end
  end

  // State and output registers; reset opens every switch immediately.
  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_q    <= S_IDLE;
      oe_n_q     <= '1;
      rr_q       <= '0;
      w_q        <= '0;
      on_cnt_q   <= '0;
      dead_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      oe_n_q     <= oe_n_d;
      rr_q       <= rr_d;
      w_q        <= w_d;
      on_cnt_q   <= on_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      armed_q    <= 1'b1;
    end
  end

  assign oe_n = oe_n_q;
  assign gnt  = ~oe_n_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_nubus_oe_sequencer.sv
// tb/tb_nubus_oe_sequencer.sv - directed and random checks for nubus_oe_sequencer
module tb_nubus_oe_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] req4;
  logic       force_off;
  logic [3:0] gnt, oe_n, gnt4, oe_n4;
  logic       busy, busy4;

  int checks;
  int errors;

  nubus_oe_sequencer #(.N_GRP(4), .DEAD_CYCLES(2), .MIN_ON(1)) dut (
    .nub_clkn(clk), .nub_resetn(rst_n), .req(req), .force_off(force_off),
    .gnt(gnt), .oe_n(oe_n), .busy(busy)
  );

  nubus_oe_sequencer #(.N_GRP(4), .DEAD_CYCLES(2), .MIN_ON(4)) dut4 (
    .nub_clkn(clk), .nub_resetn(rst_n), .req(req4), .force_off(force_off),
    .gnt(gnt4), .oe_n(oe_n4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req4 = '0; force_off = 1'b0;
    edge1();
    rst_n = 1'b1;
    edge1();
  endtask

  task automatic settle();
    req = '0; req4 = '0; force_off = 1'b0;
    repeat (5) edge1();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; req4 = '0; force_off = 1'b0;
    repeat (2) edge1();
    checks++; if (oe_n !== 4'b1111) begin errors++; $display("FAIL reset_oe_n got %b exp 1111", oe_n); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    edge1();
    checks++; if (oe_n !== 4'b1111) begin errors++; $display("FAIL reset_first_edge got %b exp 1111", oe_n); end
    edge1();
    checks++; if (oe_n !== 4'b1110) begin errors++; $display("FAIL reset_first_grant got %b exp 1110", oe_n); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got %b exp 0001", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_grant_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #2;
    checks++; if (oe_n !== 4'b1111) begin errors++; $display("FAIL reset_async_oe_n got %b exp 1111", oe_n); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_async_gnt got %b exp 0000", gnt); end
    do_reset();
  endtask

  task automatic test_pulse();
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      edge1();
      checks++; if (oe_n !== 4'b1011) begin errors++; $display("FAIL pulse_on[%0d] got %b exp 1011", i, oe_n); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pulse_busy_on[%0d] got %b exp 1", i, busy); end
    end
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      edge1();
      checks++; if (oe_n !== 4'b1111) begin errors++; $display("FAIL pulse_off[%0d] got %b exp 1111", i, oe_n); end
      checks++; if (busy !== (i < 2)) begin errors++; $display("FAIL pulse_busy_off[%0d] got %b exp %b", i, busy, (i < 2)); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    int off;
    int n;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;
    exp_g[3] = 4'b0001; exp_g[4] = 4'b0010;
    do_reset();
    req = 4'b1011;
    off = 0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin
        edge1();
        n++;
        if (gnt == 4'b0000) off++;
      end while (gnt == 4'b0000 && n < 12);
      checks++; if (gnt !== exp_g[g]) begin errors++; $display("FAIL rr_order[%0d] got %b exp %b", g, gnt, exp_g[g]); end
      if (g > 0) begin
        checks++; if (off !== 3) begin errors++; $display("FAIL rr_gap[%0d] got %0d exp 3", g, off); end
      end
      edge1();
      checks++; if (gnt !== exp_g[g]) begin errors++; $display("FAIL rr_hold[%0d] got %b exp %b", g, gnt, exp_g[g]); end
      req = req & ~exp_g[g];
      edge1();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_release[%0d] got %b exp 0000", g, gnt); end
      req = req | exp_g[g];
      off = 1;
    end
    settle();
  endtask

  task automatic test_min_on();
    req4 = 4'b0010;
    edge1();
    req4 = 4'b0000;
    checks++; if (gnt4 !== 4'b0010) begin errors++; $display("FAIL minon_grant got %b exp 0010", gnt4); end
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++; if (gnt4 !== 4'b0010) begin errors++; $display("FAIL minon_hold[%0d] got %b exp 0010", i, gnt4); end
    end
    edge1();
    checks++; if (gnt4 !== 4'b0000) begin errors++; $display("FAIL minon_release got %b exp 0000", gnt4); end
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL minon_busy got %b exp 1", busy4); end
    settle();
  endtask

  task automatic test_force_off();
    req = 4'b1000;
    edge1();
    checks++; if (oe_n !== 4'b0111) begin errors++; $display("FAIL force_pre_grant got %b exp 0111", oe_n); end
    edge1();
    force_off = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge1();
      checks++; if (oe_n !== 4'b1111) begin errors++; $display("FAIL force_held[%0d] got %b exp 1111", i, oe_n); end
    end
    force_off = 1'b0;
    for (int i = 0; i < 2; i++) begin
      edge1();
      checks++; if (oe_n !== 4'b1111) begin errors++; $display("FAIL force_dead[%0d] got %b exp 1111", i, oe_n); end
    end
    edge1();
    checks++; if (oe_n !== 4'b0111) begin errors++; $display("FAIL force_regrant got %b exp 0111", oe_n); end
    settle();
    req = 4'b0001; force_off = 1'b1;
    edge1();
    checks++; if (oe_n !== 4'b1111) begin errors++; $display("FAIL force_vs_grant got %b exp 1111", oe_n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL force_idle_busy got %b exp 1", busy); end
    settle();
  endtask

  task automatic test_random();
    logic [3:0] prev;
    int off;
    bit have_prev;
    do_reset();
    prev = '0; off = 0; have_prev = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      req = 4'($urandom);
      force_off = ($urandom_range(0, 15) == 0);
      edge1();
      checks++; if (gnt !== ~oe_n) begin errors++; $display("FAIL rand_gnt_oe[%0d] gnt %b oe_n %b", c, gnt, oe_n); end
      checks++; if (!$onehot0(gnt)) begin errors++; $display("FAIL rand_onehot[%0d] got %b exp onehot0", c, gnt); end
      if (gnt != 4'b0000) begin
        if (prev == 4'b0000) begin
          if (have_prev) begin
            checks++; if (off < 3) begin errors++; $display("FAIL rand_gap[%0d] got %0d exp >=3", c, off); end
          end
          have_prev = 1'b1;
        end else begin
          checks++; if (gnt !== prev) begin errors++; $display("FAIL rand_switch[%0d] got %b exp %b", c, gnt, prev); end
        end
        off = 0;
      end else begin
        off++;
      end
      prev = gnt;
    end
    settle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pulse();
    test_round_robin();
    test_min_on();
    test_force_off();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
